// File: rtl/fpga_io_ctrl.sv
// fpga_io_ctrl: board-level glue between the soft CPU and the FPGA pins.
// It derives the slow CPU clock pair, holds CPU reset through power-up,
// and provides LED output registers. It also debounces the keys and keeps
// sticky press flags that are cleared when the CPU reads them.
module fpga_io_ctrl #(
  parameter int HALF_PERIOD = 10000,
  parameter int STARTUP     = 1000000,
  parameter int NOUT        = 4,
  parameter int OUT_W       = 8,
  parameter int OUT_BASE    = 0,
  parameter int NKEYS       = 4,
  parameter int KEY_ADDR    = 0,
  parameter int EDGE_ADDR   = 4,
  parameter int DEBOUNCE    = 120000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             addr,
  input  logic [15:0]             bus,
  input  logic                    DI,
  input  logic                    DO,
  input  logic [NKEYS-1:0]        key,
  output logic [15:0]             busin,
  output logic                    slowclk,
  output logic                    slowclk90,
  output logic                    reset_bar,
  output logic [NOUT*OUT_W-1:0]   leds
);

  // Parameter sanity checks, evaluated at elaboration.
  if (HALF_PERIOD < 4 || (HALF_PERIOD % 2) != 0) begin : g_chk_half_period
    $error("fpga_io_ctrl: HALF_PERIOD must be >= 4 and even");
  end
  if (NOUT < 1 || NOUT > 8) begin : g_chk_nout
    $error("fpga_io_ctrl: NOUT must be 1..8");
  end
  if (OUT_W < 1 || OUT_W > 16) begin : g_chk_out_w
    $error("fpga_io_ctrl: OUT_W must be 1..16");
  end
  if (NKEYS < 1 || NKEYS > 16) begin : g_chk_nkeys
    $error("fpga_io_ctrl: NKEYS must be 1..16");
  end
  if (DEBOUNCE < 1) begin : g_chk_debounce
    $error("fpga_io_ctrl: DEBOUNCE must be >= 1");
  end
  if (EDGE_ADDR == KEY_ADDR) begin : g_chk_edge_addr
    $error("fpga_io_ctrl: EDGE_ADDR must differ from KEY_ADDR");
  end

  localparam int CW = $clog2(HALF_PERIOD);
  localparam int SW = (STARTUP < 1) ? 1 : $clog2(STARTUP + 1);
  localparam int DW = (DEBOUNCE <= 1) ? 1 : $clog2(DEBOUNCE);

  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_QTR  = CW'(HALF_PERIOD / 2 - 1);
  localparam logic [15:0]   KEY_A    = 16'(KEY_ADDR);
  localparam logic [15:0]   EDGE_A   = 16'(EDGE_ADDR);

  // ------------------------------------------------------------------
  // Slow clock generation and CPU reset
  // ------------------------------------------------------------------
  logic [SW-1:0] r_startup;
  logic          r_running;
  logic [CW-1:0] r_cnt;
  logic          r_slowclk;
  logic          r_slowclk90;
  logic          r_reset_bar;

  // Count down the settle time, then run the phase counter; slowclk90 only
  // starts once slowclk has produced its first rise so that it always lags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_startup   <= SW'(STARTUP);
      r_running   <= 1'b0;
      r_cnt       <= '0;
      r_slowclk   <= 1'b0;
      r_slowclk90 <= 1'b0;
      r_reset_bar <= 1'b0;
    end else if (!r_running) begin
      if (r_startup != '0) begin
        r_startup <= r_startup - SW'(1);
      end else begin
        r_running <= 1'b1;
        r_cnt     <= '0;
      end
    end else begin
      if (r_cnt == CNT_LAST) begin
        r_cnt       <= '0;
        r_slowclk   <= ~r_slowclk;
        r_reset_bar <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_cnt == CNT_QTR && r_reset_bar) begin
        r_slowclk90 <= ~r_slowclk90;
      end
    end
  end

  assign slowclk   = r_slowclk;
  assign slowclk90 = r_slowclk90;
  assign reset_bar = r_reset_bar;

  // ------------------------------------------------------------------
  // Output registers
  // ------------------------------------------------------------------
  logic w_unused_bus;
  assign w_unused_bus = ^bus;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
    localparam logic [15:0] REG_A = 16'(OUT_BASE + gi);
    logic [OUT_W-1:0] r_out;

    // Capture the low bits of the bus whenever this register is addressed.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_out <= '0;
      end else if (DI && addr == REG_A) begin
        r_out <= bus[OUT_W-1:0];
      end
    end

    assign leds[gi*OUT_W +: OUT_W] = (ACTIVE_LOW != 0) ? ~r_out : r_out;
  end

  // ------------------------------------------------------------------
  // Key synchronise and debounce
  // ------------------------------------------------------------------
  logic [NKEYS-1:0] w_deb;
  logic [NKEYS-1:0] w_rise;

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic [DW-1:0] r_dcnt;
    logic          w_accept;

    // The debounced level follows the synced pin only after it has
    // disagreed for DEBOUNCE consecutive cycles.
    assign w_accept = (r_sync2 != r_deb) && (r_dcnt == DW'(DEBOUNCE - 1));

    // Two-flop synchroniser followed by the stability counter.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_dcnt  <= '0;
      end else begin
        r_sync1 <= key[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_deb) begin
          r_dcnt <= '0;
        end else if (w_accept) begin
          r_deb  <= r_sync2;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end

    assign w_deb[gi]  = r_deb;
    assign w_rise[gi] = w_accept & r_sync2;
  end

  // ------------------------------------------------------------------
  // Sticky press flags with clear-on-read
  // ------------------------------------------------------------------
  logic             w_rd_edge;
  logic             r_rd_edge_q;
  logic [NKEYS-1:0] r_edge;
  logic [NKEYS-1:0] r_edge_snap;

  assign w_rd_edge = DO && (addr == EDGE_A);

  // Freeze the flags at read start; at read end clear only what was
  // reported, so rises during or at the end of a read are kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_edge_q <= 1'b0;
      r_edge      <= '0;
      r_edge_snap <= '0;
    end else begin
      r_rd_edge_q <= w_rd_edge;
      if (w_rd_edge && !r_rd_edge_q) begin
        r_edge_snap <= r_edge;
      end
      if (!w_rd_edge && r_rd_edge_q) begin
        r_edge <= (r_edge & ~r_edge_snap) | w_rise;
      end else begin
        r_edge <= r_edge | w_rise;
      end
    end
  end

  // Zero-latency read mux; idle bus reads as zero.
  always_comb begin
    busin = '0;
    if (DO && addr == KEY_A) begin
      busin[NKEYS-1:0] = w_deb;
    end else if (w_rd_edge) begin
      busin[NKEYS-1:0] = r_edge_snap;
    end
  end

endmodule

// File: tb/tb_fpga_io_ctrl.sv
// Directed bench for fpga_io_ctrl with a small timing configuration.
module tb_fpga_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] bus;
  logic        DI;
  logic        DO;
  logic [3:0]  key;
  logic [15:0] busin;
  logic        slowclk;
  logic        slowclk90;
  logic        reset_bar;
  logic [31:0] leds;
  logic [15:0] busin_al;
  logic        slowclk_al;
  logic        slowclk90_al;
  logic        reset_bar_al;
  logic [31:0] leds_al;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpga_io_ctrl #(
    .HALF_PERIOD(8), .STARTUP(20), .DEBOUNCE(5), .ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .reset(reset), .addr(addr), .bus(bus), .DI(DI), .DO(DO),
    .key(key), .busin(busin), .slowclk(slowclk), .slowclk90(slowclk90),
    .reset_bar(reset_bar), .leds(leds)
  );

  fpga_io_ctrl #(
    .HALF_PERIOD(8), .STARTUP(20), .DEBOUNCE(5), .ACTIVE_LOW(1)
  ) u_dut_al (
    .clk(clk), .reset(reset), .addr(addr), .bus(bus), .DI(DI), .DO(DO),
    .key(key), .busin(busin_al), .slowclk(slowclk_al), .slowclk90(slowclk90_al),
    .reset_bar(reset_bar_al), .leds(leds_al)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset at a falling edge and measure the startup/clock timing.
  task automatic startup_seq(input string tag);
    int n;
    logic [2:0] st;
    reset = 1'b0;
    n  = 0;
    st = 3'b000;
    while (n < 100 && st == 3'b000) begin
      @(negedge clk);
      n++;
      st = {slowclk, slowclk90, reset_bar};
    end
    chk({tag, "_first_rise_edge"}, n, 29);
    chk({tag, "_first_rise_state"}, {29'd0, st}, 32'b101);
    n = 0;
    while (n < 100 && slowclk90 == 1'b0) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_clk90_lag"}, n, 4);
    n = 0;
    while (n < 100 && slowclk == 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_clk_fall_after_90"}, n, 4);
    n = 0;
    while (n < 100 && slowclk == 1'b0) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_clk_low_half"}, n, 8);
    chk({tag, "_reset_bar_held"}, {31'd0, reset_bar}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    addr  = 16'd0;
    bus   = 16'd0;
    DI    = 1'b0;
    DO    = 1'b0;
    key   = 4'd0;
    cyc(3);

    // Reset state
    chk("rst_clocks", {29'd0, slowclk, slowclk90, reset_bar}, 32'd0);
    chk("rst_leds", leds, 32'h0000_0000);
    chk("rst_leds_al", leds_al, 32'hFFFF_FFFF);
    chk("rst_busin_idle", {16'd0, busin}, 32'd0);

    startup_seq("start");

    // Output register writes
    addr = 16'd2; bus = 16'h00A5; DI = 1'b1;
    cyc(3);
    DI = 1'b0;
    cyc(1);
    chk("wr_reg2", leds, 32'h00A5_0000);
    chk("wr_reg2_al", leds_al, 32'hFF5A_FFFF);
    addr = 16'd4; bus = 16'hFFFF; DI = 1'b1;
    cyc(2);
    DI = 1'b0;
    cyc(1);
    chk("wr_out_of_range", leds, 32'h00A5_0000);
    addr = 16'd3; bus = 16'h1234; DI = 1'b1;
    cyc(1);
    DI = 1'b0;
    cyc(1);
    chk("wr_reg3_trunc", leds, 32'h34A5_0000);
    addr = 16'd0;
    chk("rd_idle_zero", {16'd0, busin}, 32'd0);

    // Short glitch must be rejected
    key = 4'b0010;
    cyc(3);
    key = 4'b0000;
    cyc(12);
    DO = 1'b1; addr = 16'd0;
    cyc(1);
    chk("glitch_deb", {16'd0, busin}, 32'd0);
    addr = 16'd4;
    cyc(2);
    chk("glitch_edge", {16'd0, busin}, 32'd0);
    DO = 1'b0;
    cyc(2);

    // Held key: debounced level appears 2+DEBOUNCE cycles after the pin
    DO = 1'b1; addr = 16'd0;
    key = 4'b0010;
    cyc(6);
    chk("deb_lat6", {16'd0, busin}, 32'h0000);
    cyc(1);
    chk("deb_lat7", {16'd0, busin}, 32'h0002);
    cyc(3);
    key = 4'b0000;
    addr = 16'd4;
    cyc(2);
    chk("edge_key1", {16'd0, busin}, 32'h0002);
    DO = 1'b0;
    cyc(15);
    DO = 1'b1; addr = 16'd0;
    cyc(1);
    chk("deb_release", {16'd0, busin}, 32'h0000);
    DO = 1'b0;
    cyc(2);

    // Press during a read is reported by the following read
    key = 4'b0001;
    cyc(10);
    DO = 1'b1; addr = 16'd4;
    cyc(2);
    chk("edge_key0", {16'd0, busin}, 32'h0001);
    key = 4'b0101;
    cyc(10);
    chk("edge_frozen_in_read", {16'd0, busin}, 32'h0001);
    addr = 16'd0;
    cyc(1);
    chk("deb_keys_0_2", {16'd0, busin}, 32'h0005);
    DO = 1'b0;
    cyc(2);
    DO = 1'b1; addr = 16'd4;
    cyc(2);
    chk("edge_key2_next_read", {16'd0, busin}, 32'h0004);
    DO = 1'b0;
    cyc(2);
    DO = 1'b1;
    cyc(2);
    chk("edge_cleared", {16'd0, busin}, 32'h0000);
    DO = 1'b0;
    key = 4'b0000;
    cyc(12);

    // Mid-run reset with a pending press flag
    key = 4'b1000;
    cyc(10);
    key = 4'b0000;
    n = 0;
    while (n < 40 && slowclk == 1'b0) begin
      cyc(1);
      n++;
    end
    chk("slowclk_high_before_reset", {31'd0, slowclk}, 32'd1);
    reset = 1'b1;
    cyc(1);
    chk("midrst_clocks", {29'd0, slowclk, slowclk90, reset_bar}, 32'd0);
    chk("midrst_leds", leds, 32'h0000_0000);
    chk("midrst_leds_al", leds_al, 32'hFFFF_FFFF);
    cyc(1);
    startup_seq("restart");
    DO = 1'b1; addr = 16'd4;
    cyc(2);
    chk("midrst_edge_cleared", {16'd0, busin}, 32'h0000);
    DO = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
